// File: rtl/ascon_dma_sched.sv
// Job sequencer for the ASCON user-domain DMA engines: holds a descriptor,
// issues key / data / tag DMA commands in order and tracks their completion.
module ascon_dma_sched #(
    parameter int unsigned KeyBytes      = 16,
    parameter int unsigned TimeoutCycles = 4096,
    parameter int unsigned CntWidth      = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_we_i,
    input  logic [2:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic        key_arvalid_o,
    input  logic        key_arready_i,
    output logic [31:0] key_araddr_o,
    output logic [31:0] key_arlen_o,
    output logic        bdi_arvalid_o,
    input  logic        bdi_arready_i,
    output logic [31:0] bdi_araddr_o,
    output logic [31:0] bdi_arlen_o,
    output logic        bdo_awvalid_o,
    input  logic        bdo_awready_i,
    output logic [31:0] bdo_awaddr_o,
    output logic [31:0] bdo_awlen_o,
    output logic        tag_awvalid_o,
    input  logic        tag_awready_i,
    output logic [31:0] tag_awaddr_o,
    output logic [31:0] tag_awlen_o,
    input  logic        key_last_i,
    input  logic        bdi_last_i,
    input  logic        bdo_done_i,
    input  logic        tag_done_i,
    output logic [7:0]  status_o,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY_CMD, S_KEY_WAIT, S_DATA_CMD,
        S_DATA_WAIT, S_TAG_CMD, S_TAG_WAIT, S_DONE
    } state_e;

    localparam logic [CntWidth-1:0] TO_LAST = CntWidth'(TimeoutCycles - 1);

    state_e              r_state, w_state_next;
    logic [31:0]         r_key_addr, r_bdi_addr, r_bdi_len, r_bdo_addr, r_tag_addr;
    logic                r_bdi_acc, r_bdo_acc, r_bdi_last, r_bdo_done;
    logic                w_bdi_acc_next, w_bdo_acc_next, w_bdi_last_next, w_bdo_done_next;
    logic [CntWidth-1:0] r_cnt, w_cnt_next;
    logic                r_busy, r_done, r_err, r_aborted, r_irq;
    logic                w_ctrl_wr, w_start_ok, w_abort_ok, w_counting, w_timeout;
    logic                w_bdi_acc_now, w_bdo_acc_now, w_bdi_flag, w_bdo_flag, w_in_data;

    assign w_ctrl_wr     = cfg_we_i && (cfg_addr_i == 3'd5);
    assign w_abort_ok    = w_ctrl_wr && cfg_wdata_i[1] && (r_state != S_IDLE);
    assign w_start_ok    = w_ctrl_wr && cfg_wdata_i[0] && !cfg_wdata_i[1] && (r_state == S_IDLE);
    assign w_counting    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_timeout     = (TimeoutCycles != 0) && w_counting && (r_cnt == TO_LAST);
    assign w_in_data     = (r_state == S_DATA_CMD) || (r_state == S_DATA_WAIT);
    assign w_bdi_acc_now = r_bdi_acc | bdi_arready_i;
    assign w_bdo_acc_now = r_bdo_acc | bdo_awready_i;
    assign w_bdi_flag    = r_bdi_last | bdi_last_i;
    assign w_bdo_flag    = r_bdo_done | bdo_done_i;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_start_ok) w_state_next = S_KEY_CMD;
            S_KEY_CMD:   if (key_arready_i) w_state_next = S_KEY_WAIT;
            S_KEY_WAIT:  if (key_last_i) w_state_next = (r_bdi_len == '0) ? S_TAG_CMD : S_DATA_CMD;
            S_DATA_CMD:  if (w_bdi_acc_now && w_bdo_acc_now) w_state_next = S_DATA_WAIT;
            S_DATA_WAIT: if (w_bdi_flag && w_bdo_flag) w_state_next = S_TAG_CMD;
            S_TAG_CMD:   if (tag_awready_i) w_state_next = S_TAG_WAIT;
            S_TAG_WAIT:  if (tag_done_i) w_state_next = S_DONE;
            S_DONE:      w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
        if (w_abort_ok || w_timeout) w_state_next = S_IDLE;

        // Accept flags live only inside DATA_CMD; completion flags persist across DATA_CMD/DATA_WAIT.
        w_bdi_acc_next  = 1'b0;
        w_bdo_acc_next  = 1'b0;
        w_bdi_last_next = 1'b0;
        w_bdo_done_next = 1'b0;
        if (r_state == S_DATA_CMD && w_state_next == S_DATA_CMD) begin
            w_bdi_acc_next = w_bdi_acc_now;
            w_bdo_acc_next = w_bdo_acc_now;
        end
        if (w_in_data && (w_state_next == S_DATA_CMD || w_state_next == S_DATA_WAIT)) begin
            w_bdi_last_next = w_bdi_flag;
            w_bdo_done_next = w_bdo_flag;
        end

        w_cnt_next = '0;
        if (w_state_next == r_state && w_counting)
            w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_key_addr <= '0;
            r_bdi_addr <= '0;
            r_bdi_len  <= '0;
            r_bdo_addr <= '0;
            r_tag_addr <= '0;
            r_bdi_acc  <= 1'b0;
            r_bdo_acc  <= 1'b0;
            r_bdi_last <= 1'b0;
            r_bdo_done <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_aborted  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bdi_acc  <= w_bdi_acc_next;
            r_bdo_acc  <= w_bdo_acc_next;
            r_bdi_last <= w_bdi_last_next;
            r_bdo_done <= w_bdo_done_next;
            r_cnt      <= w_cnt_next;
            r_irq      <= 1'b0;

            if (cfg_we_i && r_state == S_IDLE) begin
                case (cfg_addr_i)
                    3'd0:    r_key_addr <= cfg_wdata_i;
                    3'd1:    r_bdi_addr <= cfg_wdata_i;
                    3'd2:    r_bdi_len  <= cfg_wdata_i;
                    3'd3:    r_bdo_addr <= cfg_wdata_i;
                    3'd4:    r_tag_addr <= cfg_wdata_i;
                    default: ;
                endcase
            end

            if (w_start_ok) begin
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
                r_err     <= 1'b0;
                r_aborted <= 1'b0;
            end else if (w_abort_ok) begin
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
                r_irq     <= 1'b1;
            end else if (w_timeout) begin
                r_busy <= 1'b0;
                r_err  <= 1'b1;
                r_irq  <= 1'b1;
            end else if (w_state_next == S_DONE && r_state != S_DONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_irq  <= 1'b1;
            end
        end
    end

    assign key_arvalid_o = (r_state == S_KEY_CMD);
    assign bdi_arvalid_o = (r_state == S_DATA_CMD) && !r_bdi_acc;
    assign bdo_awvalid_o = (r_state == S_DATA_CMD) && !r_bdo_acc;
    assign tag_awvalid_o = (r_state == S_TAG_CMD);
    assign key_araddr_o  = r_key_addr;
    assign bdi_araddr_o  = r_bdi_addr;
    assign bdo_awaddr_o  = r_bdo_addr;
    assign tag_awaddr_o  = r_tag_addr;
    assign key_arlen_o   = 32'(KeyBytes);
    assign tag_awlen_o   = 32'(KeyBytes);
    assign bdi_arlen_o   = r_bdi_len;
    assign bdo_awlen_o   = r_bdi_len;
    assign status_o      = {4'b0000, r_aborted, r_err, r_done, r_busy};
    assign irq_o         = r_irq;

endmodule

// File: tb/tb_ascon_dma_sched.sv
// Directed bench for ascon_dma_sched: table-driven jobs plus hand-written
// sequences for early capture, timeout, abort, busy writes and async reset.
module tb_ascon_dma_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        key_rdy = 1'b1, bdi_rdy = 1'b1, bdo_rdy = 1'b1, tag_rdy = 1'b1;
    logic        key_last = 1'b0, bdi_last = 1'b0, bdo_done = 1'b0, tag_done = 1'b0;

    logic        key_v, bdi_v, bdo_v, tag_v, irq;
    logic [31:0] key_a, key_l, bdi_a, bdi_l, bdo_a, bdo_l, tag_a, tag_l;
    logic [7:0]  status;

    logic        to_key_v, to_bdi_v, to_bdo_v, to_tag_v, to_irq;
    logic [31:0] to_key_a, to_key_l, to_bdi_a, to_bdi_l, to_bdo_a, to_bdo_l, to_tag_a, to_tag_l;
    logic [7:0]  to_status;

    int n_checks = 0;
    int n_errors = 0;
    int irq_total = 0;

    always #5 clk = ~clk;

    ascon_dma_sched dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .key_arvalid_o(key_v), .key_arready_i(key_rdy), .key_araddr_o(key_a), .key_arlen_o(key_l),
        .bdi_arvalid_o(bdi_v), .bdi_arready_i(bdi_rdy), .bdi_araddr_o(bdi_a), .bdi_arlen_o(bdi_l),
        .bdo_awvalid_o(bdo_v), .bdo_awready_i(bdo_rdy), .bdo_awaddr_o(bdo_a), .bdo_awlen_o(bdo_l),
        .tag_awvalid_o(tag_v), .tag_awready_i(tag_rdy), .tag_awaddr_o(tag_a), .tag_awlen_o(tag_l),
        .key_last_i(key_last), .bdi_last_i(bdi_last), .bdo_done_i(bdo_done), .tag_done_i(tag_done),
        .status_o(status), .irq_o(irq)
    );

    ascon_dma_sched #(.TimeoutCycles(8)) dut_to (
        .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .key_arvalid_o(to_key_v), .key_arready_i(key_rdy), .key_araddr_o(to_key_a), .key_arlen_o(to_key_l),
        .bdi_arvalid_o(to_bdi_v), .bdi_arready_i(bdi_rdy), .bdi_araddr_o(to_bdi_a), .bdi_arlen_o(to_bdi_l),
        .bdo_awvalid_o(to_bdo_v), .bdo_awready_i(bdo_rdy), .bdo_awaddr_o(to_bdo_a), .bdo_awlen_o(to_bdo_l),
        .tag_awvalid_o(to_tag_v), .tag_awready_i(tag_rdy), .tag_awaddr_o(to_tag_a), .tag_awlen_o(to_tag_l),
        .key_last_i(key_last), .bdi_last_i(bdi_last), .bdo_done_i(bdo_done), .tag_done_i(tag_done),
        .status_o(to_status), .irq_o(to_irq)
    );

    always @(negedge clk) if (irq === 1'b1) irq_total++;

    typedef struct {
        logic [31:0] key, bdi, len, bdo, tag;
        int          kdelay;
        logic        exp_data;
        logic [7:0]  exp_status;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic program_job(input logic [31:0] k, b, l, o, t);
        wr(3'd0, k); wr(3'd1, b); wr(3'd2, l); wr(3'd3, o); wr(3'd4, t);
    endtask

    task automatic pulse_key();  key_last = 1'b1; step(); key_last = 1'b0; endtask
    task automatic pulse_tag();  tag_done = 1'b1; step(); tag_done = 1'b0; endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int irq_base;
        vecs[0] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_0020, 32'h0000_3000, 32'h0000_4000, 5, 1'b1, 8'h02};
        vecs[1] = '{32'h1111_0000, 32'h2222_0004, 32'h0000_0000, 32'h3333_0008, 32'h4444_000C, 2, 1'b0, 8'h02};
        vecs[2] = '{32'hFFFF_FFF0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFC, 1, 1'b1, 8'h02};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_status", {24'b0, status}, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_valids", {28'b0, key_v, bdi_v, bdo_v, tag_v}, 32'h0);
        chk("reset_key_addr", key_a, 32'h0);
        chk("reset_bdi_len", bdi_l, 32'h0);

        wr(3'd5, 32'h3);
        chk("start_abort_idle_status", {24'b0, status}, 32'h0);
        chk("start_abort_idle_keyv", {31'b0, key_v}, 32'h0);

        for (int i = 0; i < 3; i++) begin
            program_job(vecs[i].key, vecs[i].bdi, vecs[i].len, vecs[i].bdo, vecs[i].tag);
            irq_base = irq_total;
            wr(3'd5, 32'h1);
            chk($sformatf("v%0d_key_valid", i), {31'b0, key_v}, 32'h1);
            chk($sformatf("v%0d_key_addr", i), key_a, vecs[i].key);
            chk($sformatf("v%0d_key_len", i), key_l, 32'd16);
            chk($sformatf("v%0d_busy", i), {24'b0, status}, 32'h01);
            step();
            chk($sformatf("v%0d_key_valid_drop", i), {31'b0, key_v}, 32'h0);
            repeat (vecs[i].kdelay - 1) step();
            pulse_key();
            if (vecs[i].exp_data) begin
                chk($sformatf("v%0d_data_valids", i), {30'b0, bdi_v, bdo_v}, 32'h3);
                chk($sformatf("v%0d_bdi_addr", i), bdi_a, vecs[i].bdi);
                chk($sformatf("v%0d_bdi_len", i), bdi_l, vecs[i].len);
                chk($sformatf("v%0d_bdo_addr", i), bdo_a, vecs[i].bdo);
                chk($sformatf("v%0d_bdo_len", i), bdo_l, vecs[i].len);
                step();
                chk($sformatf("v%0d_data_valids_drop", i), {30'b0, bdi_v, bdo_v}, 32'h0);
                bdi_last = 1'b1; bdo_done = 1'b1;
                step();
                bdi_last = 1'b0; bdo_done = 1'b0;
            end else begin
                chk($sformatf("v%0d_no_data_valids", i), {30'b0, bdi_v, bdo_v}, 32'h0);
            end
            chk($sformatf("v%0d_tag_valid", i), {31'b0, tag_v}, 32'h1);
            chk($sformatf("v%0d_tag_addr", i), tag_a, vecs[i].tag);
            chk($sformatf("v%0d_tag_len", i), tag_l, 32'd16);
            step();
            pulse_tag();
            chk($sformatf("v%0d_done_status", i), {24'b0, status}, {24'b0, vecs[i].exp_status});
            chk($sformatf("v%0d_done_irq", i), {31'b0, irq}, 32'h1);
            step();
            chk($sformatf("v%0d_irq_drop", i), {31'b0, irq}, 32'h0);
            chk($sformatf("v%0d_irq_count", i), irq_total - irq_base, 1);
        end

        // bdo_done captured early in DATA_CMD while bdi_arready is low
        program_job(32'h100, 32'h200, 32'h40, 32'h300, 32'h400);
        bdi_rdy = 1'b0;
        wr(3'd5, 32'h1);
        step();
        pulse_key();
        chk("early_both_valid", {30'b0, bdi_v, bdo_v}, 32'h3);
        step();
        chk("early_bdo_drop_bdi_hold", {30'b0, bdi_v, bdo_v}, 32'h2);
        bdo_done = 1'b1;
        step();
        bdo_done = 1'b0;
        chk("early_bdi_addr_stable", bdi_a, 32'h200);
        chk("early_bdi_still_valid", {31'b0, bdi_v}, 32'h1);
        step();
        bdi_rdy = 1'b1;
        step();
        chk("early_bdi_accepted", {31'b0, bdi_v}, 32'h0);
        repeat (9) step();
        chk("early_no_tag_yet", {31'b0, tag_v}, 32'h0);
        bdi_last = 1'b1;
        step();
        bdi_last = 1'b0;
        chk("early_tag_after_bdi_last", {31'b0, tag_v}, 32'h1);
        step();
        pulse_tag();
        chk("early_done_status", {24'b0, status}, 32'h02);
        step();

        // abort in DATA_WAIT, then restart with busy writes and async reset
        program_job(32'h1000, 32'h2000, 32'h20, 32'h3000, 32'h4000);
        wr(3'd5, 32'h1);
        step();
        pulse_key();
        step();
        chk("abort_pre_busy", {24'b0, status}, 32'h01);
        irq_base = irq_total;
        wr(3'd5, 32'h2);
        chk("abort_status", {24'b0, status}, 32'h08);
        chk("abort_irq", {31'b0, irq}, 32'h1);
        chk("abort_valids", {28'b0, key_v, bdi_v, bdo_v, tag_v}, 32'h0);
        wr(3'd0, 32'h5000);
        wr(3'd5, 32'h1);
        chk("restart_key_addr", key_a, 32'h5000);
        chk("restart_status", {24'b0, status}, 32'h01);
        wr(3'd3, 32'hDEAD);
        wr(3'd5, 32'h1);
        chk("busy_start_ignored", {31'b0, key_v}, 32'h0);
        chk("busy_status", {24'b0, status}, 32'h01);
        pulse_key();
        chk("busy_bdo_addr_kept", bdo_a, 32'h3000);
        chk("busy_job_continues", {31'b0, bdi_v}, 32'h1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valids", {28'b0, key_v, bdi_v, bdo_v, tag_v}, 32'h0);
        chk("async_rst_status", {24'b0, status}, 32'h0);
        chk("async_rst_irq", {31'b0, irq}, 32'h0);
        chk("async_rst_key_addr", key_a, 32'h0);
        chk("async_rst_bdo_addr", bdo_a, 32'h0);
        step();
        rst_n = 1'b1;

        // timeout: dut_to has TimeoutCycles=8, key_last never arrives
        wr(3'd0, 32'h6000);
        wr(3'd5, 32'h1);
        chk("to_key_addr", to_key_a, 32'h6000);
        step();
        repeat (7) step();
        chk("to_still_busy", {24'b0, to_status}, 32'h01);
        step();
        chk("to_err_status", {24'b0, to_status}, 32'h04);
        chk("to_irq", {31'b0, to_irq}, 32'h1);
        chk("to_valid_drop", {31'b0, to_key_v}, 32'h0);
        chk("to_main_busy", {24'b0, status}, 32'h01);
        wr(3'd5, 32'h2);
        chk("to_main_aborted", {24'b0, status}, 32'h08);
        chk("to_abort_idle_noeffect", {24'b0, to_status}, 32'h04);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
